// File: rtl/mem_access_unit_if.sv
// Load/store request, load response and D_memory bus for mem_access_unit.
// slave is the unit's view; master is the pipeline plus memory side.
interface mem_access_unit_if #(
  parameter int DSIZE     = 16,
  parameter int MEM_SPACE = 8,
  parameter int TAG_W     = 4
);
  logic                 req_valid;
  logic                 req_ready;
  logic [2:0]           req_op;
  logic [MEM_SPACE:0]   req_addr;
  logic [DSIZE-1:0]     req_wdata;
  logic [TAG_W-1:0]     req_tag;
  logic [MEM_SPACE-1:0] mem_addr;
  logic [DSIZE-1:0]     mem_wdata;
  logic                 mem_we;
  logic [DSIZE-1:0]     mem_rdata;
  logic                 rsp_valid;
  logic [DSIZE-1:0]     rsp_data;
  logic [TAG_W-1:0]     rsp_tag;
  logic                 err;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, req_tag, mem_rdata,
    output req_ready, mem_addr, mem_wdata, mem_we, rsp_valid, rsp_data, rsp_tag, err
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata, req_tag, mem_rdata,
    input  req_ready, mem_addr, mem_wdata, mem_we, rsp_valid, rsp_data, rsp_tag, err
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store front-end to D_memory: 2-cycle pipelined loads, single-cycle SW,
// and byte stores done as a read-modify-write through the SB_MERGE state.
module mem_access_unit #(
  parameter int DSIZE     = 16,
  parameter int MEM_SPACE = 8,
  parameter int TAG_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  mem_access_unit_if.slave  bus
);
  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] SB_MERGE = 1'b1;

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LB  = 3'b001;
  localparam logic [2:0] OP_LBU = 3'b010;
  localparam logic [2:0] OP_SW  = 3'b100;
  localparam logic [2:0] OP_SB  = 3'b101;

  logic [0:0]           state;
  logic                 accept, bad, ld_go, sw_go, sb_go;
  logic                 is_lw, is_lb, is_lbu, is_sw, is_sb;
  logic [MEM_SPACE-1:0] sb_word;
  logic                 sb_hi;
  logic [7:0]           sb_byte;
  logic [2:1]           vld_pipe;
  logic                 ld_hi, ld_sext, ld_word;
  logic [TAG_W-1:0]     ld_tag;
  logic [7:0]           ld_byte;
  logic [DSIZE-1:0]     ld_fmt, merged, rsp_data_q;
  logic [TAG_W-1:0]     rsp_tag_q;

  assign is_lw  = (bus.req_op == OP_LW);
  assign is_lb  = (bus.req_op == OP_LB);
  assign is_lbu = (bus.req_op == OP_LBU);
  assign is_sw  = (bus.req_op == OP_SW);
  assign is_sb  = (bus.req_op == OP_SB);

  assign bus.req_ready = !rst && (state == IDLE);
  assign accept        = bus.req_valid && bus.req_ready;

  // Illegal ops and odd-address word accesses take the handshake but touch nothing.
  assign bad   = !(is_lw || is_lb || is_lbu || is_sw || is_sb) ||
                 ((is_lw || is_sw) && bus.req_addr[0]);
  assign ld_go = accept && !bad && (is_lw || is_lb || is_lbu);
  assign sw_go = accept && !bad && is_sw;
  assign sb_go = accept && !bad && is_sb;
  assign bus.err = accept && bad;

  assign merged = sb_hi ? {sb_byte, bus.mem_rdata[7:0]}
                        : {bus.mem_rdata[DSIZE-1:8], sb_byte};

  assign bus.mem_addr  = (state == SB_MERGE) ? sb_word : bus.req_addr[MEM_SPACE:1];
  assign bus.mem_we    = !rst && (sw_go || (state == SB_MERGE));
  assign bus.mem_wdata = rst ? '0 : (state == SB_MERGE) ? merged : bus.req_wdata;

  assign ld_byte = ld_hi ? bus.mem_rdata[15:8] : bus.mem_rdata[7:0];
  assign ld_fmt  = ld_word ? bus.mem_rdata
                           : {{(DSIZE-8){ld_sext & ld_byte[7]}}, ld_byte};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      vld_pipe   <= '0;
      rsp_data_q <= '0;
      rsp_tag_q  <= '0;
      ld_hi      <= 1'b0;
      ld_sext    <= 1'b0;
      ld_word    <= 1'b0;
      ld_tag     <= '0;
      sb_word    <= '0;
      sb_hi      <= 1'b0;
      sb_byte    <= '0;
    end else begin
      state    <= sb_go ? SB_MERGE : IDLE;
      vld_pipe <= {vld_pipe[1], ld_go};
      if (ld_go) begin
        ld_hi   <= bus.req_addr[0];
        ld_sext <= is_lb;
        ld_word <= is_lw;
        ld_tag  <= bus.req_tag;
      end
      if (sb_go) begin
        sb_word <= bus.req_addr[MEM_SPACE:1];
        sb_hi   <= bus.req_addr[0];
        sb_byte <= bus.req_wdata[7:0];
      end
      // Stage-1 data is the load's own read; an SB accepted now reads on the next cycle.
      if (vld_pipe[1]) begin
        rsp_data_q <= ld_fmt;
        rsp_tag_q  <= ld_tag;
      end
    end
  end

  assign bus.rsp_valid = vld_pipe[2];
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_tag   = rsp_tag_q;
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Load/store front-end between the EX/MEM pipeline register and D_memory. It decodes word and byte loads and stores, and drives D_memory's address, write data and write enable. It absorbs D_memory's one-cycle registered read latency and returns formatted load results to write-back. D_memory has no byte enables, so byte stores are done as a two-cycle read-modify-write.

Parameters:
DSIZE, 16, data word width; matches `DSIZE.
MEM_SPACE, 8, word-address width; matches `MEM_SPACE.
TAG_W, 4, width of the tag (destination register) passed from request to response.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous, active-high reset.
req_valid  in  1  request present.
req_ready  out  1  unit can accept a request this cycle.
req_op  in  3  000 LW, 001 LB, 010 LBU, 100 SW, 101 SB; all other codes are illegal.
req_addr  in  MEM_SPACE+1  byte address: word index = [MEM_SPACE:1]; bit 0 selects the byte (0 = bits [7:0], 1 = bits [15:8]).
req_wdata  in  DSIZE  store data; SB uses bits [7:0].
req_tag  in  TAG_W  tag carried to the response.
mem_addr  out  MEM_SPACE  to D_memory address.
mem_wdata  out  DSIZE  to D_memory data_in.
mem_we  out  1  to D_memory write_en, active high.
mem_rdata  in  DSIZE  from D_memory data_out.
rsp_valid  out  1  one-cycle pulse: load result valid.
rsp_data  out  DSIZE  formatted load result.
rsp_tag  out  TAG_W  tag of the returning load.
err  out  1  one-cycle pulse: illegal op or misaligned LW/SW.

Behaviour:
- Accept: a request is accepted when req_valid and req_ready are both high. Reset-state req_ready is 0 during rst. Otherwise req_ready = 1 in IDLE and 0 in SB_MERGE.
- Address path: in the accept cycle, mem_addr = req_addr[MEM_SPACE:1] combinationally, so D_memory samples it at the same edge.
- FSM states: IDLE and SB_MERGE.
  - IDLE + accepted SB -> SB_MERGE.
  - SB_MERGE -> IDLE unconditionally after one cycle.
  - rst -> IDLE from any state.
- LW/LB/LBU, accepted in cycle N:
  - D_memory presents mem_rdata in cycle N+1.
  - The unit registers the formatted result at the end of N+1; rsp_valid = 1 in cycle N+2 only. Latency is 2.
  - Loads fully pipeline: one accept per cycle gives one rsp_valid per cycle.
  - No backpressure on the response path.
- Load formatting:
  - LW returns the word.
  - LB sign-extends the selected byte to DSIZE.
  - LBU zero-extends the selected byte.
  - rsp_tag is the tag captured at accept.
- SW: in the accept cycle, mem_we = 1 and mem_wdata = req_wdata. The write lands at that edge. No response.
- SB: accepted in cycle N.
  - Cycle N issues a read, with mem_we = 0.
  - In cycle N+1 (SB_MERGE), mem_addr holds the latched word index and mem_we = 1.
  - mem_wdata = mem_rdata with the selected byte replaced by the latched req_wdata[7:0]. The write lands at the end of N+1.
  - No response.
- Misaligned access: LW or SW with req_addr[0] = 1 is still accepted (consumes the handshake), but does not access memory and leaves mem_we = 0. err = 1 in the accept cycle.
- Illegal op: handled the same way as a misaligned access.
- Ordering:
  - A store followed by a load to the same word the next accepted cycle returns the new data. The write edge precedes the read edge, so no forwarding is needed.
  - A load accepted in cycle N and an SB accepted in N+1 may overlap. Their mem_rdata returns are distinct cycles and must not be confused.
- mem_we = 0 whenever not in the SW accept cycle or SB_MERGE, and always during rst.
- Reset, synchronous:
  - rsp_valid, err, mem_we and req_ready = 0.
  - rsp_data, rsp_tag and mem_wdata = 0.
  - The pipeline valid bit and state are cleared.
  - A pending SB merge or in-flight load is abandoned: no write occurs, no response is produced.
- Widths: all byte select and extension is fixed at 8 bits. DSIZE must be 16.

Test Plan:
- Preload word 5 = 0x8123. LW addr 10, tag 3 -> cycle N+2: rsp_valid = 1, rsp_data = 0x8123, rsp_tag = 3; rsp_valid = 0 at N+1 and N+3.
- LB addr 11 -> 0xFF81; LBU addr 11 -> 0x0081; LB addr 10 -> 0x0023; issued back-to-back -> three consecutive rsp_valid pulses, in order.
- SB addr 11, wdata 0x0055 -> req_ready = 0 for one cycle, mem_we = 1 in N+1 with mem_wdata = 0x5523; following LW addr 10 -> 0x5523.
- SW addr 12, wdata 0xBEEF, then LW addr 12 in the next cycle -> rsp_data = 0xBEEF.
- LW addr 11 (odd) and op 011 -> err pulse in the accept cycle, mem_we = 0, no rsp_valid.
- rst asserted in the SB_MERGE cycle -> mem_we = 0 that cycle; after rst, rsp_valid = 0 and req_ready = 1 in IDLE.
